seq_adder_subtractor: RTL and testbench
=======================================

SEQ_ADDER_SUBTRACTOR -- requirements
Module: seq_adder_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; SHALL be >= 1 and divide WIDTH exactly. NCH = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and mode are presented.
REQ-006 in_ready  output  1  block accepts an operation; high only in IDLE.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 c  input  1  mode: 0 = a+b, 1 = a-b (two's complement).
REQ-010 sum  output  WIDTH  registered result.
REQ-011 c_out  output  1  final carry out of MSB (subtract: 1 = no borrow).
REQ-012 ovf  output  1  signed two's-complement overflow.
REQ-013 zero  output  1  high when sum is all zeros.
REQ-014 out_valid  output  1  result outputs are valid.
REQ-015 out_ready  input  1  consumer takes the result.

Function
REQ-016 FSM SHALL have three states: IDLE, CALC, DONE.
REQ-017 IDLE: in_valid=1 at a rising edge SHALL latch a, b XOR {WIDTH{c}}, carry=c, chunk index=0, and enter CALC.
REQ-018 CALC: each cycle SHALL add CHUNK bits of a and the inverted-or-plain b at index*CHUNK, plus carry; write those sum bits; update carry; increment index.
REQ-019 The edge processing chunk NCH-1 SHALL enter DONE and set out_valid=1; latency is exactly NCH cycles from the accept edge to out_valid high.
REQ-020 ovf SHALL equal carry into the MSB XOR carry out of the MSB; c_out SHALL equal the final carry.
REQ-021 DONE: sum, c_out, ovf, zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 DONE with out_ready=1 at an edge SHALL clear out_valid and return to IDLE; the next accept is possible one cycle later (one-cycle bubble).
REQ-023 in_valid outside IDLE SHALL be ignored; a, b, c changes during CALC/DONE SHALL NOT affect the result.
REQ-024 Output registers SHALL keep the previous result values in IDLE; only out_valid qualifies them.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, sum=0, c_out=0, ovf=0, zero=0, out_valid=0, in_ready=1, chunk index=0, carry=0.
REQ-026 Reset in CALC or DONE SHALL abandon the operation; no out_valid pulse for it SHALL ever appear.

Configuration
REQ-027 Macro ADDSUB_SAT_EN defined: when ovf=1, sum SHALL saturate to 0x7F..F (overflow with MSB of raw result = 1) or 0x80..0 (overflow with raw MSB = 0); ovf still reports 1; zero SHALL be computed on the saturated value.
REQ-028 Macro ADDSUB_SAT_EN undefined: sum SHALL be the raw wrapped WIDTH-bit result; no saturation logic present.

Verification (WIDTH=16, CHUNK=4)
REQ-029 a=0x1234, b=0x0FFF, c=0 -> sum=0x2233, c_out=0, ovf=0, zero=0, out_valid exactly 4 cycles after accept.
REQ-030 a=0x0005, b=0x0007, c=1 -> sum=0xFFFE, c_out=0, ovf=0.
REQ-031 a=0x7FFF, b=0x0001, c=0 -> ovf=1; sum=0x8000 without ADDSUB_SAT_EN, 0x7FFF with it.
REQ-032 a=0xFFFF, b=0x0001, c=0 -> sum=0x0000, c_out=1, zero=1, ovf=0.
REQ-033 out_ready held 0 for 3 cycles in DONE with in_valid=1 and new operands -> outputs stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE, next op accepted one cycle later.
REQ-034 rst_n pulsed low after 2 CALC cycles -> out_valid=0, in_ready=1 immediately; subsequent 0x0001+0x0001 yields sum=0x0002 after 4 cycles.

Source files
------------

// File: rtl/seq_adder_subtractor.sv
// -----------------------------------------------------------------------------
// seq_adder_subtractor
//   Multi-cycle adder/subtractor. An accepted operation is processed CHUNK
//   bits per clock, LSB chunk first, over NCH = WIDTH/CHUNK cycles. Result,
//   carry-out, signed overflow and zero flag are registered and held until
//   the consumer takes them.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits added per cycle (>= 1, must divide WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operation presented (a, b, c)
//   in_ready   high only while idle
//   a, b       operands
//   c          mode: 0 = a+b, 1 = a-b
//   sum        registered result
//   c_out      carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//   zero       sum is all zeros
//   out_valid  result outputs valid
//   out_ready  consumer takes the result
//
// Build option
//   ADDSUB_SAT_EN  when defined, overflowing results saturate to the most
//                  positive / most negative signed value.
// -----------------------------------------------------------------------------
module seq_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operands are shifted right one chunk per cycle so the active chunk is
  // always in the low bits.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_a_ch;
  logic [CHUNK-1:0] w_b_ch;
  logic [CHUNK:0]   w_ch_sum;
  logic             w_cin_msb;
  logic             w_ovf;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final;
  logic             w_zero;

  assign w_a_ch   = r_a[CHUNK-1:0];
  assign w_b_ch   = r_b[CHUNK-1:0];
  assign w_ch_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the chunk's top bit, recovered from its sum bit; on the last
  // chunk this is the carry into the word MSB.
  assign w_cin_msb = w_a_ch[CHUNK-1] ^ w_b_ch[CHUNK-1] ^ w_ch_sum[CHUNK-1];
  assign w_ovf     = w_cin_msb ^ w_ch_sum[CHUNK];
  assign w_last    = (r_idx == LAST_IDX);

  // New chunk enters at the top of the accumulator; after NCH cycles the
  // first chunk has reached bit 0 and the accumulator holds the full result.
  assign w_acc_next = WIDTH'({w_ch_sum[CHUNK-1:0], r_acc} >> CHUNK);

`ifdef ADDSUB_SAT_EN
  always_comb begin
    w_final = w_acc_next;
    if (w_ovf) begin
      if (w_acc_next[WIDTH-1]) w_final = {1'b0, {(WIDTH-1){1'b1}}};
      else                     w_final = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  assign w_final = w_acc_next;
`endif

  assign w_zero = (w_final == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{c}};
            r_carry <= c;
            r_idx   <= '0;
          end
        end
        CALC: begin
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_acc   <= w_acc_next;
          r_carry <= w_ch_sum[CHUNK];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_idx   <= '0;
            r_sum   <= w_final;
            r_c_out <= w_ch_sum[CHUNK];
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;
  assign zero  = r_zero;

endmodule

// File: tb/tb_seq_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_seq_adder_subtractor
//   Self-checking bench for seq_adder_subtractor (WIDTH=16, CHUNK=4).
//   Expected results come from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_seq_adder_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         zero;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_adder_subtractor #(
    .WIDTH(16),
    .CHUNK(4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf),
    .zero     (zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Reference: {sum, c_out, ovf, zero} from integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc);
    int sa, sb, sr;
    logic [W-1:0] r;
    logic co, ov;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (mc) begin
      r  = ma - mb;
      co = (ma >= mb);
      sr = sa - sb;
    end else begin
      r  = ma + mb;
      co = (int'(ma) + int'(mb)) > 65535;
      sr = sa + sb;
    end
    ov = (sr > 32767) || (sr < -32768);
`ifdef ADDSUB_SAT_EN
    if (sr > 32767)       r = 16'h7FFF;
    else if (sr < -32768) r = 16'h8000;
`endif
    return {r, co, ov, (r == '0)};
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int hold, input string name);
    logic [W+2:0] e_v;
    int lat;
    e_v = model(ta, tb, tc);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready_before: in_ready=%b expected 1", name, in_ready);
    end
    a = ta; b = tb; c = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles expected 4", name, lat);
      if (lat >= 20) return;
    end
    n_tests++;
    if ({sum, c_out, ovf, zero} !== e_v) begin
      n_fail++;
      $display("FAIL %s_result: sum=%h c_out=%b ovf=%b zero=%b expected sum=%h c_out=%b ovf=%b zero=%b",
               name, sum, c_out, ovf, zero, e_v[W+2:3], e_v[2], e_v[1], e_v[0]);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if ({sum, c_out, ovf, zero, out_valid, in_ready} !== {e_v, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL %s_hold%0d: sum=%h flags=%b%b%b ov=%b ir=%b expected sum=%h flags=%b ov=1 ir=0",
                 name, i, sum, c_out, ovf, zero, out_valid, in_ready, e_v[W+2:3], e_v[2:0]);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    n_tests++;
    if ({sum, c_out, ovf, zero, out_valid, in_ready} !== {e_v, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_release: sum=%h flags=%b%b%b ov=%b ir=%b expected sum=%h flags=%b ov=0 ir=1",
               name, sum, c_out, ovf, zero, out_valid, in_ready, e_v[W+2:3], e_v[2:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_tests++;
    if ({sum, c_out, ovf, zero, out_valid, in_ready} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: sum=%h c_out=%b ovf=%b zero=%b ov=%b ir=%b expected 0000 0 0 0 0 1",
               sum, c_out, ovf, zero, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    run_op(16'h1234, 16'h0FFF, 1'b0, 0, "add_basic");
    run_op(16'h0005, 16'h0007, 1'b1, 0, "sub_neg");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "add_wrap_zero");
    run_op(16'h8000, 16'h0001, 1'b1, 0, "sub_ovf");
  endtask

  task automatic test_stall();
    run_op(16'h4321, 16'h1111, 1'b1, 3, "stall");
  endtask

  task automatic test_back_to_back();
    run_op(16'h00FF, 16'h0001, 1'b0, 0, "b2b_0");
    run_op(16'h0100, 16'h0100, 1'b1, 0, "b2b_1");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             $sformatf("rand%0d", k));
  endtask

  // Reset after 'edges' cycles past the accept edge; the operation must vanish.
  task automatic test_reset_mid(input int edges, input string name);
    bit seen;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (edges) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({sum, c_out, ovf, zero, out_valid, in_ready} !== {16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_async: sum=%h c_out=%b ovf=%b zero=%b ov=%b ir=%b expected 0000 0 0 0 0 1",
               name, sum, c_out, ovf, zero, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s_no_pulse: out_valid=1 seen expected never", name);
    end
    run_op(16'h0001, 16'h0001, 1'b0, 0, {name, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_vectors();
    test_stall();
    test_back_to_back();
    test_reset_mid(2, "rst_calc");
    test_reset_mid(4, "rst_done");
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
